sc_sa_cache: RTL and testbench
==============================

# sc_sa_cache

Parametrised N-way set-associative cache, the successor to the direct-mapped simple cache; sits between a RI5CY-style core LSU/IF port and the memory-side req/gnt/rvalid port in front of the AXI bridge. One-word lines, write-through/no-write-allocate, per-set round-robin replacement with invalid-way preference, single-cycle flush, saturating hit/miss counters. `NUM_WAYS=1` reproduces direct-mapped behaviour.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width; fixed 32 (be width 4)
- `NUM_WAYS`, 2, associativity; power of two, ≥1
- `NUM_SETS`, 64, sets; power of two, ≥2
- `clk` in 1, single clock
- `rst` in 1, asynchronous, active-high reset
- `flush_i` in 1, invalidate all lines (pulse)
- `cpu_req_i` in 1, core request
- `cpu_gnt_o` out 1, request accepted this cycle
- `cpu_addr_i` in ADDR_WIDTH, byte address
- `cpu_we_i` in 1, 1=write
- `cpu_be_i` in 4, byte enables
- `cpu_wdata_i` in 32, write data
- `cpu_rvalid_o` out 1, response valid (reads and writes)
- `cpu_rdata_o` out 32, read data
- `mem_req_o` out 1, memory request, held until `mem_gnt_i`
- `mem_gnt_i` in 1, memory grant
- `mem_addr_o` out ADDR_WIDTH, memory address
- `mem_we_o` / `mem_be_o` / `mem_wdata_o` out 1/4/32, memory write controls
- `mem_rvalid_i` in 1, memory response
- `mem_rdata_i` in 32, memory read data
- `hit_count_o` / `miss_count_o` out 32, saturating lookup counters

## Operation
- Address split: offset [1:0] ignored; index = addr[2 +: log2(NUM_SETS)]; tag = remaining upper bits. Tag/data/valid storage in flops; victim pointer per set, width max(1, log2(NUM_WAYS)).
- States: IDLE, LOOKUP, MEM_REQ, MEM_WAIT.
- IDLE: if flush pending or `flush_i` → clear all valid bits and victim pointers this cycle, `cpu_gnt_o`=0. Else `cpu_gnt_o` = `cpu_req_i`; on grant register addr/we/be/wdata → LOOKUP.
- LOOKUP: parallel tag compare against all valid ways of the set.
  - Read hit: `cpu_rvalid_o`=1, `cpu_rdata_o`=hit way data, hit_count++, → IDLE.
  - Read miss: miss_count++, → MEM_REQ (we=0, be=4'hF, addr word-aligned).
  - Write: hit → merge `wdata` into hit way under `be`, hit_count++; miss → miss_count++, no allocate. Always → MEM_REQ (we=1, full address, be, wdata).
- MEM_REQ: `mem_req_o`=1 with stable controls; on `mem_gnt_i` → MEM_WAIT.
- MEM_WAIT: on `mem_rvalid_i`: `cpu_rvalid_o`=1 same cycle; read: `cpu_rdata_o`=`mem_rdata_i`, fill victim way (tag, data, valid=1); → IDLE.
- Victim: lowest-index invalid way; if none, way at set pointer, then pointer increments mod NUM_WAYS. Pointer untouched when an invalid way is filled.
- Multiple ways matching impossible by construction; no priority logic required beyond lowest index.
- `flush_i` outside IDLE sets flush-pending; flush executes on first IDLE cycle, before any new grant. In-flight miss fill still completes before flush.
- Counters saturate at 32'hFFFF_FFFF; cleared only by reset.

## Timing
- Reset (async, immediate): state IDLE, all valid bits 0, pointers 0, counters 0, flush-pending 0; `cpu_gnt_o`, `cpu_rvalid_o`, `mem_req_o`, `mem_we_o` = 0; `cpu_rdata_o`, `mem_addr_o`, `mem_be_o`, `mem_wdata_o` = 0.
- Read hit: grant cycle T, `cpu_rvalid_o` at T+1. Back-to-back hits: one every 2 cycles.
- Miss/write: `mem_req_o` asserted at T+2; `cpu_rvalid_o` coincident with `mem_rvalid_i`; zero-wait memory (gnt same cycle, rvalid next) → rvalid at T+3.
- `cpu_gnt_o` is 0 in all states except IDLE; at most one outstanding request.
- `mem_rvalid_i` outside MEM_WAIT ignored (covers stale responses after reset).
- `cpu_rvalid_o` is a single-cycle pulse per granted request.

## Test plan
- Reset, read 0x100 (mem=0xDEADBEEF) → miss, `mem_req_o` with addr 0x100, rvalid data 0xDEADBEEF; reread 0x100 → hit at T+1, hit_count=1, miss_count=1.
- NUM_WAYS=2, NUM_SETS=64: read 0x000, 0x100, 0x200 (same set 0) → all misses; 0x200 evicts way 0 (0x000); reread 0x100 → hit, 0x000 → miss.
- Write 0x100 be=4'b0011 wdata=0x0000_1234 after cached 0xDEADBEEF → memory write issued with be 0011, reread hits 0xDEAD1234; write to uncached 0x300 → memory write, later read 0x300 misses.
- `flush_i` pulsed during a miss in MEM_WAIT → fill completes and rvalid issued, next IDLE cycle no grant, subsequent read of same address misses.
- Assert `rst` while in MEM_WAIT, then deliver `mem_rvalid_i` → no `cpu_rvalid_o`, counters 0, all lines invalid.
- `mem_gnt_i` held low 5 cycles → `mem_req_o` and address stable throughout; NUM_WAYS=1 build reproduces direct-mapped hit/miss sequence.

Source files
------------

// File: rtl/sc_sa_cache.sv
// sc_sa_cache: N-way set-associative, one-word-line, write-through /
// no-write-allocate cache between a core LSU/IF port and a req/gnt/rvalid
// memory port. Per-set round-robin replacement that prefers invalid ways,
// single-cycle flush, saturating hit/miss counters.
//
// Ports:
//   clk, rst          single clock, async active-high reset
//   flush_i           invalidate all lines (deferred to IDLE if busy)
//   cpu_*             core side: req/gnt handshake, addr/we/be/wdata,
//                     rvalid/rdata response (one pulse per granted request)
//   mem_*             memory side: req held until gnt, then wait for rvalid
//   hit/miss_count_o  saturating lookup counters
module sc_sa_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WAYS   = 2,
    parameter int NUM_SETS   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  cpu_req_i,
    output logic                  cpu_gnt_o,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic                  cpu_we_i,
    input  logic [3:0]            cpu_be_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic                  cpu_rvalid_o,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_WAIT} state_t;

    state_t                                  state_q, state_d;
    logic                                    flush_pend_q, flush_pend_d;
    logic [ADDR_WIDTH-1:0]                   req_addr_q, req_addr_d;
    logic                                    req_we_q, req_we_d;
    logic [3:0]                              req_be_q, req_be_d;
    logic [DATA_WIDTH-1:0]                   req_wdata_q, req_wdata_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]       valid_q, valid_d;
    logic [NUM_SETS-1:0][WAY_W-1:0]          ptr_q, ptr_d;
    logic [TAG_W-1:0]                        tag_q  [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]                        tag_d  [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0]                   data_q [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0]                   data_d [NUM_SETS][NUM_WAYS];
    logic [31:0]                             hit_cnt_q, hit_cnt_d;
    logic [31:0]                             miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic                  vic_inv;
    logic [WAY_W-1:0]      vic_way;
    logic [DATA_WIDTH-1:0] merged;

    assign req_idx = req_addr_q[2 +: IDX_W];
    assign req_tag = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

    // Tag compare and victim choice for the latched request's set.
    // Lowest-index match/invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_inv = 1'b0;
        vic_way = ptr_q[req_idx];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!vic_inv && !valid_q[req_idx][w]) begin
                vic_inv = 1'b1;
                vic_way = WAY_W'(w);
            end
        end
        merged = data_q[req_idx][hit_way];
        for (int b = 0; b < 4; b++)
            if (req_be_q[b]) merged[8*b +: 8] = req_wdata_q[8*b +: 8];
    end

    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        req_addr_d   = req_addr_q;
        req_we_d     = req_we_q;
        req_be_d     = req_be_q;
        req_wdata_d  = req_wdata_q;
        valid_d      = valid_q;
        ptr_d        = ptr_q;
        tag_d        = tag_q;
        data_d       = data_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        cpu_gnt_o    = 1'b0;
        cpu_rvalid_o = 1'b0;
        cpu_rdata_o  = '0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_wdata_o  = '0;

        // A flush seen while busy is remembered and done on the next IDLE cycle.
        if (state_q != S_IDLE && flush_i) flush_pend_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (flush_pend_q || flush_i) begin
                    valid_d      = '0;
                    ptr_d        = '0;
                    flush_pend_d = 1'b0;
                end else begin
                    cpu_gnt_o = cpu_req_i;
                    if (cpu_req_i) begin
                        req_addr_d  = cpu_addr_i;
                        req_we_d    = cpu_we_i;
                        req_be_d    = cpu_be_i;
                        req_wdata_d = cpu_wdata_i;
                        state_d     = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                if (hit) hit_cnt_d  = (&hit_cnt_q)  ? hit_cnt_q  : hit_cnt_q + 32'd1;
                else     miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 32'd1;
                if (!req_we_q && hit) begin
                    cpu_rvalid_o = 1'b1;
                    cpu_rdata_o  = data_q[req_idx][hit_way];
                    state_d      = S_IDLE;
                end else begin
                    // Writes always go through; a hit line is updated in place.
                    if (req_we_q && hit) data_d[req_idx][hit_way] = merged;
                    state_d = S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = req_we_q ? req_addr_q : {req_addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_we_o    = req_we_q;
                mem_be_o    = req_we_q ? req_be_q : 4'hF;
                mem_wdata_o = req_wdata_q;
                if (mem_gnt_i) state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (mem_rvalid_i) begin
                    cpu_rvalid_o = 1'b1;
                    if (!req_we_q) begin
                        cpu_rdata_o                = mem_rdata_i;
                        tag_d[req_idx][vic_way]    = req_tag;
                        data_d[req_idx][vic_way]   = mem_rdata_i;
                        valid_d[req_idx][vic_way]  = 1'b1;
                        // Round-robin only advances when a valid line is evicted.
                        if (!vic_inv)
                            ptr_d[req_idx] = (ptr_q[req_idx] == WAY_W'(NUM_WAYS-1)) ?
                                             '0 : ptr_q[req_idx] + WAY_W'(1);
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            flush_pend_q <= 1'b0;
            req_addr_q   <= '0;
            req_we_q     <= 1'b0;
            req_be_q     <= '0;
            req_wdata_q  <= '0;
            valid_q      <= '0;
            ptr_q        <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            req_addr_q   <= req_addr_d;
            req_we_q     <= req_we_d;
            req_be_q     <= req_be_d;
            req_wdata_q  <= req_wdata_d;
            valid_q      <= valid_d;
            ptr_q        <= ptr_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Tag/data arrays need no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_sc_sa_cache.sv
// Self-checking bench for sc_sa_cache (2 ways, 64 sets). A behavioural
// cache/memory model predicts every cycle's outputs; a negedge process
// compares them, and directed literal checks pin the model.
module tb_sc_sa_cache;
    localparam int NW = 2;
    localparam int NS = 64;

    logic        clk = 0, rst = 1, flush_i = 0;
    logic        cpu_req_i = 0, cpu_gnt_o, cpu_we_i = 0, cpu_rvalid_o;
    logic [31:0] cpu_addr_i = 0, cpu_wdata_i = 0, cpu_rdata_o;
    logic [3:0]  cpu_be_i = 0, mem_be_o;
    logic        mem_req_o, mem_gnt_i = 0, mem_we_o, mem_rvalid_i = 0;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = 0;
    logic [31:0] hit_count_o, miss_count_o;

    sc_sa_cache #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WAYS(NW), .NUM_SETS(NS)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .cpu_req_i(cpu_req_i), .cpu_gnt_o(cpu_gnt_o), .cpu_addr_i(cpu_addr_i),
        .cpu_we_i(cpu_we_i), .cpu_be_i(cpu_be_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          m_vld [NS][NW];
    int unsigned m_tag [NS][NW];
    bit [31:0]   m_dat [NS][NW];
    int          m_ptr [NS];
    bit [31:0]   m_hits = 0, m_miss = 0;
    bit          m_fpend = 0, last_hit = 0;
    bit [31:0]   mem [int unsigned];

    function automatic bit [31:0] sat(input bit [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 1;
    endfunction
    function automatic int unsigned set_of(input bit [31:0] a); return (a / 4) % NS; endfunction
    function automatic int unsigned tag_of(input bit [31:0] a); return a / (4 * NS); endfunction
    function automatic bit [31:0] memrd(input int unsigned w);
        return mem.exists(w) ? mem[w] : (w * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction
    function automatic bit [31:0] merge(input bit [31:0] o, input bit [3:0] be, input bit [31:0] d);
        bit [31:0] r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction
    function automatic bit lookup(input bit [31:0] a, output int way);
        way = 0;
        for (int w = 0; w < NW; w++)
            if (m_vld[set_of(a)][w] && m_tag[set_of(a)][w] == tag_of(a)) begin way = w; return 1; end
        return 0;
    endfunction
    function automatic void mclear();
        for (int s = 0; s < NS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < NW; w++) m_vld[s][w] = 0;
        end
    endfunction
    function automatic void fill(input bit [31:0] a, input bit [31:0] d);
        int s = set_of(a), v = -1;
        for (int w = 0; w < NW; w++) if (v < 0 && !m_vld[s][w]) v = w;
        if (v < 0) begin v = m_ptr[s]; m_ptr[s] = (m_ptr[s] + 1) % NW; end
        m_vld[s][v] = 1; m_tag[s][v] = tag_of(a); m_dat[s][v] = d;
    endfunction

    // ---------------- per-cycle expectations + compare ----------------
    bit          chk_en = 0;
    bit          e_gnt = 0, e_rvalid = 0, e_chkdat = 0, e_mreq = 0, e_mwe = 0;
    bit [31:0]   e_rdata = 0, e_maddr = 0, e_mwdata = 0;
    bit [3:0]    e_mbe = 0;
    logic [31:0] obs_rdata = 0;

    always @(negedge clk) if (chk_en) begin
        chk("cpu_gnt", 32'(cpu_gnt_o), 32'(e_gnt));
        chk("cpu_rvalid", 32'(cpu_rvalid_o), 32'(e_rvalid));
        if (e_rvalid && e_chkdat) chk("cpu_rdata", cpu_rdata_o, e_rdata);
        if (cpu_rvalid_o) obs_rdata = cpu_rdata_o;
        chk("mem_req", 32'(mem_req_o), 32'(e_mreq));
        if (e_mreq) begin
            chk("mem_addr", mem_addr_o, e_maddr);
            chk("mem_we", 32'(mem_we_o), 32'(e_mwe));
            chk("mem_be", 32'(mem_be_o), 32'(e_mbe));
            if (e_mwe) chk("mem_wdata", mem_wdata_o, e_mwdata);
        end
        chk("hit_count", hit_count_o, m_hits);
        chk("miss_count", miss_count_o, m_miss);
    end

    task automatic cyc(); @(posedge clk); #1; endtask

    task automatic idle(input int n);
        cpu_req_i = 0; e_gnt = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (m_fpend) begin mclear(); m_fpend = 0; end
        end
    endtask

    task automatic flush_idle();
        cpu_req_i = 1'($urandom_range(0, 1)); flush_i = 1; e_gnt = 0;
        cyc();
        flush_i = 0; cpu_req_i = 0; mclear(); m_fpend = 0;
    endtask

    // One complete request from IDLE back to IDLE.
    task automatic access(input bit [31:0] a, input bit we, input bit [3:0] be, input bit [31:0] wd,
                          input int gd, input int rd, input bit fl);
        int w; bit h; bit [31:0] rdat;
        int unsigned s = set_of(a);
        cpu_req_i = 1; cpu_addr_i = a; cpu_we_i = we; cpu_be_i = be; cpu_wdata_i = wd;
        if (m_fpend) begin e_gnt = 0; cyc(); mclear(); m_fpend = 0; end
        e_gnt = 1;
        cyc();
        cpu_req_i = 0; cpu_addr_i = $urandom; cpu_wdata_i = $urandom; cpu_be_i = 4'($urandom);
        e_gnt = 0;
        h = lookup(a, w); last_hit = h;
        if (!we && h) begin
            e_rvalid = 1; e_chkdat = 1; e_rdata = m_dat[s][w];
            cyc();
            e_rvalid = 0; m_hits = sat(m_hits);
            return;
        end
        cyc();
        if (h) m_hits = sat(m_hits); else m_miss = sat(m_miss);
        if (we && h) m_dat[s][w] = merge(m_dat[s][w], be, wd);
        e_mreq = 1; e_maddr = we ? a : (a & ~32'h3); e_mwe = we; e_mbe = we ? be : 4'hF; e_mwdata = wd;
        for (int i = 0; i < gd; i++) begin
            mem_rvalid_i = 1'($urandom_range(0, 1)); mem_rdata_i = $urandom;  // stale, must be ignored
            cyc();
        end
        mem_rvalid_i = 0; mem_gnt_i = 1;
        cyc();
        mem_gnt_i = 0; e_mreq = 0;
        if (fl) flush_i = 1;
        for (int i = 0; i < rd; i++) begin cyc(); flush_i = 0; end
        rdat = we ? $urandom : memrd(a / 4);
        mem_rvalid_i = 1; mem_rdata_i = rdat; e_rvalid = 1; e_chkdat = !we; e_rdata = rdat;
        cyc();
        flush_i = 0; mem_rvalid_i = 0; e_rvalid = 0;
        if (fl) m_fpend = 1;
        if (we) mem[a / 4] = merge(memrd(a / 4), be, wd);
        else    fill(a, rdat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    bit [31:0] ra, rw; bit rwe; bit [3:0] rbe; int unsigned rr;

    initial begin
        mclear();
        repeat (2) cyc();
        // reset state
        chk("rst_gnt", 32'(cpu_gnt_o), 0);   chk("rst_rvalid", 32'(cpu_rvalid_o), 0);
        chk("rst_mreq", 32'(mem_req_o), 0);  chk("rst_mwe", 32'(mem_we_o), 0);
        chk("rst_rdata", cpu_rdata_o, 0);    chk("rst_maddr", mem_addr_o, 0);
        chk("rst_mbe", 32'(mem_be_o), 0);    chk("rst_mwdata", mem_wdata_o, 0);
        chk("rst_hits", hit_count_o, 0);     chk("rst_miss", miss_count_o, 0);
        rst = 0; chk_en = 1;

        // miss then hit on 0x100
        mem[32'h100 / 4] = 32'hDEAD_BEEF;
        access(32'h100, 0, 4'h0, 0, 0, 0, 0);
        chk("t1_hit", 32'(last_hit), 0); chk("t1_rdata", obs_rdata, 32'hDEAD_BEEF);
        access(32'h100, 0, 4'h0, 0, 0, 0, 0);
        chk("t2_hit", 32'(last_hit), 1); chk("t2_rdata", obs_rdata, 32'hDEAD_BEEF);
        chk("t2_hits", hit_count_o, 1);  chk("t2_miss", miss_count_o, 1);

        // replacement in set 0
        flush_idle();
        access(32'h000, 0, 0, 0, 0, 0, 0); chk("t3_000", 32'(last_hit), 0);
        access(32'h100, 0, 0, 0, 0, 0, 0); chk("t3_100", 32'(last_hit), 0);
        access(32'h200, 0, 0, 0, 0, 0, 0); chk("t3_200", 32'(last_hit), 0);
        access(32'h100, 0, 0, 0, 0, 0, 0); chk("t3_100b", 32'(last_hit), 1);
        access(32'h000, 0, 0, 0, 0, 0, 0); chk("t3_000b", 32'(last_hit), 0);
        chk("t3_hits", hit_count_o, 2); chk("t3_miss", miss_count_o, 5);

        // write-through with byte enables, and no-write-allocate
        access(32'h100, 0, 0, 0, 0, 1, 0);
        access(32'h100, 1, 4'b0011, 32'h0000_1234, 0, 0, 0); chk("t4_whit", 32'(last_hit), 1);
        access(32'h100, 0, 0, 0, 0, 0, 0);
        chk("t4_rhit", 32'(last_hit), 1); chk("t4_rdata", obs_rdata, 32'hDEAD_1234);
        access(32'h300, 1, 4'hF, 32'hCAFE_F00D, 1, 0, 0); chk("t4_wmiss", 32'(last_hit), 0);
        access(32'h300, 0, 0, 0, 0, 0, 0);
        chk("t4_rmiss", 32'(last_hit), 0); chk("t4_rdata300", obs_rdata, 32'hCAFE_F00D);

        // flush during MEM_WAIT
        access(32'h400, 0, 0, 0, 0, 2, 1);
        access(32'h400, 0, 0, 0, 0, 0, 0); chk("t5_flushed", 32'(last_hit), 0);

        // reset while in MEM_WAIT, then a stale response
        cpu_req_i = 1; cpu_addr_i = 32'h500; cpu_we_i = 0; e_gnt = 1;
        cyc();
        cpu_req_i = 0; e_gnt = 0;
        cyc();
        m_miss = sat(m_miss);
        e_mreq = 1; e_maddr = 32'h500; e_mwe = 0; e_mbe = 4'hF; mem_gnt_i = 1;
        cyc();
        mem_gnt_i = 0; e_mreq = 0; chk_en = 0; rst = 1;
        #1;
        chk("t6_rvalid", 32'(cpu_rvalid_o), 0); chk("t6_mreq", 32'(mem_req_o), 0);
        chk("t6_hits", hit_count_o, 0);        chk("t6_miss", miss_count_o, 0);
        cyc();
        rst = 0; mclear(); m_hits = 0; m_miss = 0; m_fpend = 0; chk_en = 1;
        mem_rvalid_i = 1; mem_rdata_i = 32'h1111_2222;
        cyc();
        mem_rvalid_i = 0;
        access(32'h100, 0, 0, 0, 0, 0, 0);
        chk("t6_inval", 32'(last_hit), 0); chk("t6_miss1", miss_count_o, 1);

        // grant held off for 5 cycles
        access(32'h604, 0, 0, 0, 5, 1, 0);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            rr = $urandom_range(0, 99);
            if (rr < 4) flush_idle();
            else if (rr < 10) idle($urandom_range(1, 3));
            else begin
                ra  = $urandom_range(0, 7) * 256 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3);
                rwe = ($urandom_range(0, 9) < 3);
                rbe = 4'($urandom_range(1, 15));
                rw  = $urandom;
                access(ra, rwe, rbe, rw, $urandom_range(0, 3), $urandom_range(0, 3),
                       ($urandom_range(0, 19) == 0));
            end
        end
        idle(2);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
